limbus_timer_master: RTL and testbench
======================================

LIMBUS_TIMER_MASTER -- requirements
Module: limbus_timer_master

Interface
REQ-001 SHALL have parameter SNAP_EN, default 1, meaning 1 = read the counter snapshot on each serviced timeout and 0 = skip the snapshot read.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of tick_count.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cfg_valid  in  1  command request.
REQ-006 cfg_ready  out  1  command accepted when cfg_valid && cfg_ready.
REQ-007 cfg_op  in  1  0 = start, 1 = stop.
REQ-008 cfg_period  in  32  timer period, used by start only.
REQ-009 cfg_continuous  in  1  continuous-mode bit, used by start only.
REQ-010 cfg_irq_en  in  1  interrupt-enable bit, used by start only.
REQ-011 av_address  out  3  timer slave word address.
REQ-012 av_chipselect  out  1  slave select.
REQ-013 av_write_n  out  1  active-low write strobe.
REQ-014 av_writedata  out  16  write data.
REQ-015 av_readdata  in  16  slave read data, registered in the slave, valid 1 cycle after the address.
REQ-016 av_irq  in  1  timer interrupt, level.
REQ-017 tick_valid  out  1  one-cycle pulse per serviced timeout.
REQ-018 tick_snapshot  out  32  captured counter value, valid with tick_valid.
REQ-019 tick_count  out  CNT_W  serviced-timeout count.
REQ-020 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-021 SHALL implement an Avalon-MM master for the 16-bit interval timer: no waitrequest, each bus access lasts one cycle, and read latency is fixed at 1.
REQ-022 SHALL use FSM states IDLE, WR_PL, WR_PH, WR_CTRL, WR_STOP, CLR_ST, SNAP_WR, RD_SL, RD_SH, CAP_SH.
REQ-023 SHALL, in IDLE, drive av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0.
REQ-024 SHALL, in IDLE, give priority to av_irq: if av_irq=1, go to CLR_ST and hold cfg_ready=0 that cycle.
REQ-025 SHALL assert cfg_ready = (state==IDLE) && !av_irq.
REQ-026 SHALL, on an accepted start, latch cfg_period/cfg_continuous/cfg_irq_en, clear tick_count to 0, and sequence WR_PL -> WR_PH -> WR_CTRL -> IDLE.
REQ-027 SHALL perform these start writes: WR_PL = addr 2 with period[15:0]; WR_PH = addr 3 with period[31:16]; WR_CTRL = addr 1 with 0x0004 | cont<<1 | irq_en.
REQ-028 SHALL, on an accepted stop, go to WR_STOP, write addr 1 with 0x0008, then return to IDLE; tick_count is unchanged.
REQ-029 SHALL drive av_chipselect=1 and av_write_n=0 in every write state.
REQ-030 SHALL, in CLR_ST, write addr 0 with 0x0000; next state is SNAP_WR if SNAP_EN=1, else IDLE.
REQ-031 SHALL, in SNAP_WR, write addr 4 with 0x0000 (this latches the slave snapshot), then go to RD_SL.
REQ-032 SHALL, in RD_SL, drive a read of addr 4 (chipselect=1, write_n=1), then go to RD_SH.
REQ-033 SHALL, in RD_SH, drive a read of addr 5, capture av_readdata into snapshot[15:0], then go to CAP_SH.
REQ-034 SHALL, in CAP_SH, drive chipselect=0, capture av_readdata into snapshot[31:16], then go to IDLE.
REQ-035 SHALL pulse tick_valid for exactly one cycle: the cycle after CAP_SH (SNAP_EN=1) or the cycle after CLR_ST (SNAP_EN=0).
REQ-036 SHALL increment tick_count in the same cycle as tick_valid, wrapping from 2^CNT_W-1 to 0.
REQ-037 SHALL keep tick_snapshot unchanged when SNAP_EN=0 (stays 0 after reset).
REQ-038 SHALL NOT service av_irq mid-sequence; an irq raised during a command or service sequence is handled on the next IDLE cycle, and no irq is lost because it is level-sensitive.
REQ-039 SHALL ignore cfg_valid whenever cfg_ready=0; cfg fields are sampled only at acceptance.
REQ-040 SHALL write cfg_period=0 as-is with no special handling.
REQ-041 SHALL drive every output only from registers or the FSM state, with no combinational path from inputs except cfg_ready depending on av_irq.

Reset
REQ-042 SHALL, while reset=1, force state to IDLE and tick_valid=0, tick_count=0, tick_snapshot=0, av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0, and clear the latched cfg fields.
REQ-043 SHALL abort any sequence in progress when reset asserts mid-sequence, issue no further bus cycles, and emit no tick_valid.

Verification
REQ-044 Start, period 0x0001869F, cont=1, irq_en=1 -> 3 consecutive writes: (2,0x869F), (3,0x0001), (1,0x0007); busy=1 for 3 cycles; tick_count=0.
REQ-045 av_irq asserted with the slave snapshot holding 0x00012345, SNAP_EN=1 -> writes (0,0) and (4,0), reads 4 then 5, tick_valid 1 cycle with tick_snapshot=0x00012345; tick_count +1.
REQ-046 av_irq and a start cfg_valid in the same IDLE cycle -> CLR_ST runs first, cfg_ready=0, and the start is accepted on the next IDLE cycle.
REQ-047 CNT_W=4, 16 serviced irqs -> tick_count wraps to 0; stop issued -> write (1,0x0008) and tick_count retained.
REQ-048 reset pulsed during RD_SL -> the next cycle shows chipselect=0, no tick_valid, tick_count=0, cfg_ready=1.
REQ-049 SNAP_EN=0 and an irq -> only write (0,0) occurs; tick_valid follows 1 cycle later; tick_snapshot remains 0.

Source files
------------

// File: rtl/limbus_timer_master_if.sv
// Bundles the command handshake and the Avalon-MM timer bus of limbus_timer_master.
// The master modport is the controller's view. The slave modport is the view of the
// command source plus the timer peripheral.
interface limbus_timer_master_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_op;
  logic [31:0] cfg_period;
  logic        cfg_continuous;
  logic        cfg_irq_en;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        av_irq;

  modport master (
    input  cfg_valid, cfg_op, cfg_period, cfg_continuous, cfg_irq_en,
    output cfg_ready,
    output av_address, av_chipselect, av_write_n, av_writedata,
    input  av_readdata, av_irq
  );

  modport slave (
    output cfg_valid, cfg_op, cfg_period, cfg_continuous, cfg_irq_en,
    input  cfg_ready,
    input  av_address, av_chipselect, av_write_n, av_writedata,
    output av_readdata, av_irq
  );
endinterface

// File: rtl/limbus_timer_master.sv
// Avalon-MM master for a 16-bit interval timer. It programs start and stop commands
// and services the timeout interrupt. On each serviced timeout it can also read back
// the counter snapshot.
module limbus_timer_master #(
  parameter int SNAP_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  limbus_timer_master_if.master    bus,
  output logic                     tick_valid,
  output logic [31:0]              tick_snapshot,
  output logic [CNT_W-1:0]         tick_count,
  output logic                     busy
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, WR_STOP, CLR_ST, SNAP_WR, RD_SL, RD_SH, CAP_SH
  } state_t;

  localparam logic [2:0]  ADDR_STATUS  = 3'd0;
  localparam logic [2:0]  ADDR_CONTROL = 3'd1;
  localparam logic [2:0]  ADDR_PERIODL = 3'd2;
  localparam logic [2:0]  ADDR_PERIODH = 3'd3;
  localparam logic [2:0]  ADDR_SNAPL   = 3'd4;
  localparam logic [2:0]  ADDR_SNAPH   = 3'd5;
  localparam logic [15:0] CTRL_START   = 16'h0004;
  localparam logic [15:0] CTRL_STOP    = 16'h0008;

  state_t      state_q, state_d;
  logic [31:0] period_q;
  logic        cont_q;
  logic        irq_en_q;
  logic [15:0] snap_lo_q;
  logic        accept;
  logic        tick_fire;

  // The interrupt wins over a command in IDLE, so the command is refused in that cycle.
  assign bus.cfg_ready = (state_q == IDLE) && !bus.av_irq;
  assign accept        = bus.cfg_valid && bus.cfg_ready;
  assign busy          = (state_q != IDLE);
  // The last state of a service sequence produces the tick one cycle later.
  assign tick_fire     = (SNAP_EN != 0) ? (state_q == CAP_SH) : (state_q == CLR_ST);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples
    // pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and per-state bus cycle decode
  always_comb begin
    // NOTE: every output gets a default before the case statement, so no path can
    // infer a latch.
    state_d           = state_q;
    bus.av_chipselect = 1'b0;
    bus.av_write_n    = 1'b1;
    bus.av_address    = '0;
    bus.av_writedata  = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.av_irq)  state_d = CLR_ST;
        else if (accept) state_d = bus.cfg_op ? WR_STOP : WR_PL;
      end
      WR_PL: begin
        bus.av_chipselect = 1'b1;
        bus.av_write_n    = 1'b0;
        bus.av_address    = ADDR_PERIODL;
        bus.av_writedata  = period_q[15:0];
        state_d           = WR_PH;
      end
      WR_PH: begin
        bus.av_chipselect = 1'b1;
        bus.av_write_n    = 1'b0;
        bus.av_address    = ADDR_PERIODH;
        bus.av_writedata  = period_q[31:16];
        state_d           = WR_CTRL;
      end
      WR_CTRL: begin
        bus.av_chipselect = 1'b1;
        bus.av_write_n    = 1'b0;
        bus.av_address    = ADDR_CONTROL;
        bus.av_writedata  = CTRL_START | {14'd0, cont_q, irq_en_q};
        state_d           = IDLE;
      end
      WR_STOP: begin
        bus.av_chipselect = 1'b1;
        bus.av_write_n    = 1'b0;
        bus.av_address    = ADDR_CONTROL;
        bus.av_writedata  = CTRL_STOP;
        state_d           = IDLE;
      end
      CLR_ST: begin
        bus.av_chipselect = 1'b1;
        bus.av_write_n    = 1'b0;
        bus.av_address    = ADDR_STATUS;
        state_d           = (SNAP_EN != 0) ? SNAP_WR : IDLE;
      end
      SNAP_WR: begin
        bus.av_chipselect = 1'b1;
        bus.av_write_n    = 1'b0;
        bus.av_address    = ADDR_SNAPL;
        state_d           = RD_SL;
      end
      RD_SL: begin
        bus.av_chipselect = 1'b1;
        bus.av_address    = ADDR_SNAPL;
        state_d           = RD_SH;
      end
      RD_SH: begin
        bus.av_chipselect = 1'b1;
        bus.av_address    = ADDR_SNAPH;
        state_d           = CAP_SH;
      end
      CAP_SH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the command, count ticks, and assemble the snapshot from the two reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q      <= '0;
      cont_q        <= 1'b0;
      irq_en_q      <= 1'b0;
      snap_lo_q     <= '0;
      tick_valid    <= 1'b0;
      tick_count    <= '0;
      tick_snapshot <= '0;
    end else begin
      tick_valid <= tick_fire;
      if (accept && !bus.cfg_op) begin
        period_q   <= bus.cfg_period;
        cont_q     <= bus.cfg_continuous;
        irq_en_q   <= bus.cfg_irq_en;
        tick_count <= '0;
      end else if (tick_fire) begin
        tick_count <= tick_count + CNT_W'(1);
      end
      // Read data arrives one cycle after its address. The low half is present
      // during RD_SH and the high half during CAP_SH.
      if (state_q == RD_SH)  snap_lo_q     <= bus.av_readdata;
      if (state_q == CAP_SH) tick_snapshot <= {bus.av_readdata, snap_lo_q};
    end
  end

endmodule

// File: tb/tb_limbus_timer_master.sv
// Scoreboard bench for limbus_timer_master. Instance A uses the snapshot read with a
// 16-bit counter. Instance B skips the snapshot and uses a 4-bit counter.
module tb_limbus_timer_master;

  typedef enum logic [1:0] {EV_WR, EV_RD, EV_TICK} ev_kind_t;
  typedef struct packed {
    ev_kind_t    kind;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [15:0] cnt;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  limbus_timer_master_if bus_a ();
  limbus_timer_master_if bus_b ();

  logic        tv_a, busy_a, tv_b, busy_b;
  logic [31:0] ts_a, ts_b;
  logic [15:0] tc_a;
  logic [3:0]  tc_b;

  logic        s_valid [2];
  logic        s_op    [2];
  logic [31:0] s_period[2];
  logic        s_cont  [2];
  logic        s_ien   [2];
  logic        s_irq   [2];
  logic [31:0] snap    [2];

  assign bus_a.cfg_valid      = s_valid[0];
  assign bus_a.cfg_op         = s_op[0];
  assign bus_a.cfg_period     = s_period[0];
  assign bus_a.cfg_continuous = s_cont[0];
  assign bus_a.cfg_irq_en     = s_ien[0];
  assign bus_a.av_irq         = s_irq[0];
  assign bus_b.cfg_valid      = s_valid[1];
  assign bus_b.cfg_op         = s_op[1];
  assign bus_b.cfg_period     = s_period[1];
  assign bus_b.cfg_continuous = s_cont[1];
  assign bus_b.cfg_irq_en     = s_ien[1];
  assign bus_b.av_irq         = s_irq[1];

  limbus_timer_master #(.SNAP_EN(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.master), .tick_valid(tv_a),
    .tick_snapshot(ts_a), .tick_count(tc_a), .busy(busy_a)
  );

  limbus_timer_master #(.SNAP_EN(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.master), .tick_valid(tv_b),
    .tick_snapshot(ts_b), .tick_count(tc_b), .busy(busy_b)
  );

  // Timer slave models: registered read data, one cycle of latency.
  always @(posedge clk) begin
    bus_a.av_readdata <= (bus_a.av_chipselect && bus_a.av_write_n) ?
      ((bus_a.av_address == 3'd4) ? snap[0][15:0] :
       (bus_a.av_address == 3'd5) ? snap[0][31:16] : 16'h0) : 16'h0;
    bus_b.av_readdata <= (bus_b.av_chipselect && bus_b.av_write_n) ?
      ((bus_b.av_address == 3'd4) ? snap[1][15:0] :
       (bus_b.av_address == 3'd5) ? snap[1][31:16] : 16'h0) : 16'h0;
  end

  ev_t q_a[$];
  ev_t q_b[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic ev_t wr(input logic [2:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = EV_WR; e.addr = a; e.data = d; e.cnt = 16'h0;
    return e;
  endfunction

  function automatic ev_t rd(input logic [2:0] a);
    ev_t e;
    e.kind = EV_RD; e.addr = a; e.data = 32'h0; e.cnt = 16'h0;
    return e;
  endfunction

  function automatic ev_t tk(input logic [31:0] s, input logic [15:0] c);
    ev_t e;
    e.kind = EV_TICK; e.addr = 3'd0; e.data = s; e.cnt = c;
    return e;
  endfunction

  task automatic push(input int i, input ev_t e);
    if (i == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  function automatic logic f_ready(input int i);
    return (i == 0) ? bus_a.cfg_ready : bus_b.cfg_ready;
  endfunction
  function automatic logic f_busy(input int i);
    return (i == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic f_tv(input int i);
    return (i == 0) ? tv_a : tv_b;
  endfunction
  function automatic logic [15:0] f_cnt(input int i);
    return (i == 0) ? tc_a : {12'h0, tc_b};
  endfunction
  function automatic logic f_clr(input int i);
    if (i == 0) return bus_a.av_chipselect && !bus_a.av_write_n && bus_a.av_address == 3'd0;
    return bus_b.av_chipselect && !bus_b.av_write_n && bus_b.av_address == 3'd0;
  endfunction

  // Monitor: compare every observed bus cycle or tick against the head of the queue.
  task automatic mon(input int i, input ev_t got);
    ev_t e;
    if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
      n_checks++;
      n_errors++;
      $display("FAIL mon%0d unexpected event: got %0h expected none", i, got);
    end else begin
      e = (i == 0) ? q_a.pop_front() : q_b.pop_front();
      check($sformatf("mon%0d event", i), 64'(got), 64'(e));
    end
  endtask

  always @(negedge clk) begin
    if (bus_a.av_chipselect)
      mon(0, bus_a.av_write_n ? rd(bus_a.av_address) : wr(bus_a.av_address, {16'h0, bus_a.av_writedata}));
    if (tv_a) mon(0, tk(ts_a, tc_a));
    if (bus_b.av_chipselect)
      mon(1, bus_b.av_write_n ? rd(bus_b.av_address) : wr(bus_b.av_address, {16'h0, bus_b.av_writedata}));
    if (tv_b) mon(1, tk(ts_b, {12'h0, tc_b}));
  end

  task automatic push_irq(input int i, input logic [31:0] s, input logic [15:0] c);
    push(i, wr(3'd0, 32'h0));
    if (i == 0) begin
      push(0, wr(3'd4, 32'h0));
      push(0, rd(3'd4));
      push(0, rd(3'd5));
    end
    push(i, tk(s, c));
  endtask

  // Issue one command and hold it until it is accepted. The interrupt can optionally
  // be raised in the same cycle, and it is dropped once the status register is cleared.
  task automatic do_cmd(input int i, input logic op, input logic [31:0] per,
                        input logic c, input logic ie, input bit with_irq,
                        input logic [31:0] irq_snap, input logic [15:0] irq_cnt);
    bit done = 0;
    if (with_irq) push_irq(i, irq_snap, irq_cnt);
    if (op) push(i, wr(3'd1, 32'h8));
    else begin
      push(i, wr(3'd2, {16'h0, per[15:0]}));
      push(i, wr(3'd3, {16'h0, per[31:16]}));
      push(i, wr(3'd1, {29'h0, 1'b1, c, ie}));
    end
    @(negedge clk);
    s_valid[i] = 1'b1; s_op[i] = op; s_period[i] = per; s_cont[i] = c; s_ien[i] = ie;
    if (with_irq) s_irq[i] = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      if (f_clr(i)) s_irq[i] = 1'b0;
      #1;
      if (with_irq && k == 0) check("cfg_ready low while irq pending", 64'(f_ready(i)), 64'(0));
      if (f_ready(i)) begin
        @(negedge clk);
        s_valid[i] = 1'b0;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    check("command accepted", 64'(done), 64'(1));
    s_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    for (int k = 0; k < 50 && f_busy(i); k++) @(negedge clk);
    check("returns to idle", 64'(f_busy(i)), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  // Raise the interrupt and hold it until the status clear. Then check tick latency and width.
  task automatic run_irq(input int i, input logic [31:0] s, input logic [15:0] c);
    bit seen = 0;
    int lat = 0;
    push_irq(i, s, c);
    s_irq[i] = 1'b1;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (f_clr(i)) seen = 1;
    end
    check("irq status cleared", 64'(seen), 64'(1));
    s_irq[i] = 1'b0;
    while (!f_tv(i) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("tick latency after CLR_ST", 64'(lat), (i == 0) ? 64'(5) : 64'(1));
    @(negedge clk);
    check("tick pulse width", 64'(f_tv(i)), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 0; s_op[i] = 0; s_period[i] = 0; s_cont[i] = 0; s_ien[i] = 0; s_irq[i] = 0;
    end
    snap[0] = 32'h0001_2345;
    snap[1] = 32'h0BAD_F00D;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset chipselect", 64'(bus_a.av_chipselect), 64'(0));
    check("reset write_n", 64'(bus_a.av_write_n), 64'(1));
    check("reset address", 64'(bus_a.av_address), 64'(0));
    check("reset writedata", 64'(bus_a.av_writedata), 64'(0));
    check("reset tick_valid", 64'(tv_a), 64'(0));
    check("reset tick_count", 64'(tc_a), 64'(0));
    check("reset tick_snapshot", 64'(ts_a), 64'(0));
    check("reset busy", 64'(busy_a), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    check("cfg_ready after reset", 64'(bus_a.cfg_ready), 64'(1));

    // Start with period 0x0001869F, continuous, irq enabled.
    do_cmd(0, 1'b0, 32'h0001_869F, 1'b1, 1'b1, 0, 32'h0, 16'h0);
    n = 0;
    while (busy_a && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("start busy cycles", 64'(n), 64'(3));
    check("tick_count after start", 64'(tc_a), 64'(0));
    repeat (2) @(negedge clk);

    // Serviced timeout with the snapshot read.
    run_irq(0, 32'h0001_2345, 16'd1);
    check("tick_count after first irq", 64'(tc_a), 64'(1));

    // Stop, with an interrupt raised mid-sequence: it is serviced on the next IDLE cycle.
    snap[0] = 32'h89AB_4567;
    do_cmd(0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, 32'h0, 16'h0);
    run_irq(0, 32'h89AB_4567, 16'd2);

    // Irq and start arrive in the same cycle: the irq is serviced first. Period 0 is written as-is.
    snap[0] = 32'hCAFE_0001;
    do_cmd(0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1, 32'hCAFE_0001, 16'd3);
    wait_idle(0);
    check("tick_count cleared by start", 64'(tc_a), 64'(0));
    run_irq(0, 32'hCAFE_0001, 16'd1);

    // Assert reset while the FSM is in RD_SL: the sequence aborts with no tick.
    push(0, wr(3'd0, 32'h0));
    push(0, wr(3'd4, 32'h0));
    push(0, rd(3'd4));
    s_irq[0] = 1'b1;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (f_clr(0)) s_irq[0] = 1'b0;
      if (bus_a.av_chipselect && bus_a.av_write_n && bus_a.av_address == 3'd4) found = 1;
    end
    check("reached RD_SL", 64'(found), 64'(1));
    s_irq[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("abort chipselect", 64'(bus_a.av_chipselect), 64'(0));
    check("abort tick_valid", 64'(tv_a), 64'(0));
    check("abort tick_count", 64'(tc_a), 64'(0));
    check("abort cfg_ready", 64'(bus_a.cfg_ready), 64'(1));
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Instance B: no snapshot read, 4-bit counter wraps after 16 ticks.
    do_cmd(1, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 0, 32'h0, 16'h0);
    wait_idle(1);
    for (int k = 0; k < 16; k++) run_irq(1, 32'h0, 16'((k + 1) % 16));
    check("tick_count wrapped", 64'(f_cnt(1)), 64'(0));
    check("snapshot stays 0 without SNAP_EN", 64'(ts_b), 64'(0));
    for (int k = 1; k <= 3; k++) run_irq(1, 32'h0, 16'(k));
    do_cmd(1, 1'b1, 32'h0, 1'b0, 1'b0, 0, 32'h0, 16'h0);
    wait_idle(1);
    check("tick_count retained by stop", 64'(f_cnt(1)), 64'(3));

    repeat (4) @(negedge clk);
    check("queue A drained", 64'(q_a.size()), 64'(0));
    check("queue B drained", 64'(q_b.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
